// File: rtl/lcg_stim_pkg.sv
// -----------------------------------------------------------------------------
// lcg_stim_pkg
// Shared definitions for the LCG stimulus generator:
//   LCG_MUL / LCG_INC : constants of the 32-bit LCG
//                       state' = state * LCG_MUL + LCG_INC (mod 2^32)
//   lcg_state_e       : generator FSM states
//   lcg_next()        : one LCG step
// -----------------------------------------------------------------------------
package lcg_stim_pkg;

   localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
   localparam logic [31:0] LCG_INC = 32'h0000_3039;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GEN     = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DONE    = 2'd3
   } lcg_state_e;

   // Multiplication and addition wrap at 32 bits, which is the mod 2^32.
   function automatic logic [31:0] lcg_next(input logic [31:0] s);
      return s * LCG_MUL + LCG_INC;
   endfunction

endpackage

// File: rtl/lcg32_step.sv
// -----------------------------------------------------------------------------
// lcg32_step
// Registered 32-bit LCG. The state register holds the most recently emitted
// value; next_val is the value the next advance will emit, so a consumer can
// capture next_val on the same edge that advances the state.
// Ports:
//   clk      in   clock, posedge
//   rst      in   synchronous active-high reset, loads SEED
//   load     in   load load_val into the state (wins over advance)
//   load_val in   32-bit seed value
//   advance  in   step the LCG once
//   next_val out  lcg_next(state), combinational from the state register
// -----------------------------------------------------------------------------
module lcg32_step
   import lcg_stim_pkg::*;
#(
   parameter logic [31:0] SEED = 32'd2746317213
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        advance,
   output logic [31:0] next_val
);

   logic [31:0] state_q;

   assign next_val = lcg_next(state_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
      end else if (load) begin
         state_q <= load_val;
      end else if (advance) begin
         state_q <= next_val;
      end
   end

endmodule

// File: rtl/lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// lcg_stim_gen
// Deterministic stimulus source: fills a WIDTH-bit vector one 32-bit LCG
// chunk per cycle and presents each finished vector on a valid/ready
// handshake, NUM_VECTORS vectors per run. The LCG state survives between
// vectors and runs, so the stream matches a software LCG with the same seed.
//
// Ports:
//   clk        in   sole clock, posedge
//   rst        in   synchronous active-high reset
//   seed_load  in   IDLE/DONE only: load seed_in into the LCG
//   seed_in    in   32-bit seed
//   start      in   IDLE/DONE only: begin a run (seed_load in the same cycle
//                   is applied first)
//   vec_valid  out  vec_data holds a complete vector
//   vec_ready  in   consumer accepts the vector
//   vec_data   out  vector; chunk k occupies bits [32k+31:32k], the top chunk
//                   keeps only the low bits of its LCG value
//   vec_index  out  0-based index of the presented vector
//   busy       out  generating or presenting
//   done       out  run complete, held until start or rst
//
// Handshake: a transfer happens on a posedge where vec_valid && vec_ready.
// While vec_valid is high, vec_data and vec_index do not change until that
// transfer; vec_ready has no effect while vec_valid is low. Every output is a
// flop, so nothing depends combinationally on vec_ready.
//
// Build option LCG_STIM_PREFETCH_EN: a shadow buffer keeps generating the next
// vector while the current one waits, giving one vector per NCHUNK cycles.
// Without it a single buffer is used, one vector per NCHUNK+1 cycles. The
// emitted sequence is identical either way.
// -----------------------------------------------------------------------------
module lcg_stim_gen
   import lcg_stim_pkg::*;
#(
   parameter int          WIDTH       = 345,
   parameter int          NUM_VECTORS = 21,
   parameter logic [31:0] SEED        = 32'd2746317213
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   input  logic             start,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [WIDTH-1:0] vec_data,
   output logic [15:0]      vec_index,
   output logic             busy,
   output logic             done
);

   localparam int NCHUNK = (WIDTH + 31) / 32;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int EXT_W  = NCHUNK * 32;

   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
   localparam logic [15:0]      LAST_IDX   = 16'(NUM_VECTORS - 1);

   // Write one 32-bit chunk into a vector. Work in a chunk-aligned width so
   // the top chunk simply loses the bits above WIDTH on the final cast.
   function automatic logic [WIDTH-1:0] merge_chunk(
      input logic [WIDTH-1:0] old_vec,
      input logic [CNT_W-1:0] idx,
      input logic [31:0]      val
   );
      logic [EXT_W-1:0] mask;
      logic [EXT_W-1:0] ins;
      mask = EXT_W'(32'hFFFF_FFFF) << {idx, 5'b0};
      ins  = EXT_W'(val) << {idx, 5'b0};
      return WIDTH'((EXT_W'(old_vec) & ~mask) | ins);
   endfunction

   lcg_state_e       state_q;
   lcg_state_e       state_d;
   logic [CNT_W-1:0] chunk_cnt;
   logic [31:0]      lcg_nxt;
   logic             lcg_load;
   logic             lcg_adv;
   logic             idle_like;
   logic             last_chunk;
   logic             last_vec;
   logic             handshake;

   assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign last_chunk = (chunk_cnt == LAST_CHUNK);
   assign last_vec   = (vec_index == LAST_IDX);
   // vec_valid is high exactly in PRESENT, so the state stands in for it.
   assign handshake  = (state_q == ST_PRESENT) && vec_ready;
   assign lcg_load   = idle_like && seed_load;

   lcg32_step #(
      .SEED(SEED)
   ) u_lcg (
      .clk      (clk),
      .rst      (rst),
      .load     (lcg_load),
      .load_val (seed_in),
      .advance  (lcg_adv),
      .next_val (lcg_nxt)
   );

   // State register plus status flags registered from the next state, so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         vec_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_valid <= (state_d == ST_PRESENT);
         busy      <= (state_d == ST_GEN) || (state_d == ST_PRESENT);
         done      <= (state_d == ST_DONE);
      end
   end

`ifdef LCG_STIM_PREFETCH_EN

   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] shadow_merged;
   logic [WIDTH-1:0] avail_data;
   logic             shadow_full;
   logic [15:0]      gen_cnt;
   logic             gen_run;
   logic             gen_last;
   logic             avail;
   logic             slot_free;
   logic             xfer;

   localparam logic [15:0] NUM_VEC16 = 16'(NUM_VECTORS);

   // The generator runs independently of presentation until the shadow is
   // full or every vector of the run has been produced; it never starts a
   // vector past NUM_VECTORS-1, so the LCG ends a run where it would have
   // without prefetch.
   assign gen_run       = ((state_q == ST_GEN) || (state_q == ST_PRESENT)) &&
                          !shadow_full && (gen_cnt != NUM_VEC16);
   assign gen_last      = gen_run && last_chunk;
   assign shadow_merged = merge_chunk(shadow_q, chunk_cnt, lcg_nxt);
   // A vector is available either already parked in the shadow or being
   // completed on this edge (bypass straight to the output).
   assign avail         = shadow_full || gen_last;
   assign avail_data    = shadow_full ? shadow_q : shadow_merged;
   assign slot_free     = (state_q == ST_GEN) || (handshake && !last_vec);
   assign xfer          = slot_free && avail;
   assign lcg_adv       = gen_run;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_GEN;
         ST_GEN:           if (avail) state_d = ST_PRESENT;
         ST_PRESENT: begin
            if (vec_ready) begin
               if (last_vec)   state_d = ST_DONE;
               else if (avail) state_d = ST_PRESENT;
               else            state_d = ST_GEN;
            end
         end
         default:          state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chunk_cnt   <= '0;
         vec_index   <= '0;
         vec_data    <= '0;
         shadow_q    <= '0;
         shadow_full <= 1'b0;
         gen_cnt     <= '0;
      end else if (idle_like) begin
         if (start) begin
            chunk_cnt   <= '0;
            vec_index   <= '0;
            gen_cnt     <= '0;
            shadow_full <= 1'b0;
         end
      end else begin
         if (gen_run) begin
            shadow_q  <= shadow_merged;
            chunk_cnt <= last_chunk ? '0 : chunk_cnt + CNT_W'(1);
         end
         if (gen_last) begin
            gen_cnt <= gen_cnt + 16'd1;
         end
         if (xfer) begin
            vec_data    <= avail_data;
            shadow_full <= 1'b0;
         end else if (gen_last) begin
            shadow_full <= 1'b1;
         end
         if (handshake && !last_vec) begin
            vec_index <= vec_index + 16'd1;
         end
      end
   end

`else

   // Single buffer: chunks land directly in vec_data. A half-built vector is
   // never flagged because vec_valid only rises on entry to PRESENT.
   assign lcg_adv = (state_q == ST_GEN);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_GEN;
         ST_GEN:           if (last_chunk) state_d = ST_PRESENT;
         ST_PRESENT: begin
            if (vec_ready) state_d = last_vec ? ST_DONE : ST_GEN;
         end
         default:          state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chunk_cnt <= '0;
         vec_index <= '0;
         vec_data  <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  chunk_cnt <= '0;
                  vec_index <= '0;
               end
            end
            ST_GEN: begin
               vec_data  <= merge_chunk(vec_data, chunk_cnt, lcg_nxt);
               chunk_cnt <= last_chunk ? '0 : chunk_cnt + CNT_W'(1);
            end
            ST_PRESENT: begin
               if (vec_ready && !last_vec) begin
                  vec_index <= vec_index + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_lcg_stim_gen
// Directed bench for lcg_stim_gen. u0 runs the default configuration
// (WIDTH 345, 21 vectors); u1 is a one-chunk, one-vector instance for the
// seed-1 case. Expected vectors come from a bench-side LCG model pushed into
// exp_q and popped on each presented vector.
// -----------------------------------------------------------------------------
module tb_lcg_stim_gen;

  localparam int          W     = 345;
  localparam int          NCH   = 11;
  localparam int          NV    = 21;
  localparam logic [31:0] DSEED = 32'd2746317213;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          seed_load = 1'b0;
  logic [31:0]   seed_in   = '0;
  logic          start     = 1'b0;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
  logic [W-1:0]  vec_data;
  logic [15:0]   vec_index;
  logic          busy;
  logic          done;

  logic          seed_load1 = 1'b0;
  logic [31:0]   seed_in1   = '0;
  logic          start1     = 1'b0;
  logic          vec_valid1;
  logic          vec_ready1 = 1'b0;
  logic [31:0]   vec_data1;
  logic [15:0]   vec_index1;
  logic          busy1;
  logic          done1;

  lcg_stim_gen #(.WIDTH(W), .NUM_VECTORS(NV), .SEED(DSEED)) u0 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_index(vec_index), .busy(busy), .done(done)
  );

  lcg_stim_gen #(.WIDTH(32), .NUM_VECTORS(1), .SEED(DSEED)) u1 (
    .clk(clk), .rst(rst), .seed_load(seed_load1), .seed_in(seed_in1),
    .start(start1), .vec_valid(vec_valid1), .vec_ready(vec_ready1),
    .vec_data(vec_data1), .vec_index(vec_index1), .busy(busy1), .done(done1)
  );

  // ---------------- scoreboard ----------------
  int           total = 0;
  int           bad   = 0;
  logic [31:0]  m_state;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h00003039;
  endfunction

  task automatic gen_expected();
    logic [383:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      m_state = ref_next(m_state);
      v[k*32 +: 32] = m_state;
    end
    exp_q.push_back(v[W-1:0]);
  endtask

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!vec_valid && n < limit) begin
      tick();
      n++;
    end
    check("valid_wait", 384'(vec_valid), 384'(1));
  endtask

  task automatic check_next_vec(input int idx);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 384'(exp_q.size()), 384'(1));
      last_exp = '0;
    end else begin
      last_exp = exp_q.pop_front();
    end
    check("vec_data", 384'(vec_data), 384'(last_exp));
    check("vec_index", 384'(vec_index), 384'(idx));
  endtask

  // Run with vec_ready tied high; the caller has just ticked the start edge.
  task automatic run_vectors();
    int n;
    for (int i = 0; i < NV; i++) begin
      gen_expected();
      wait_valid(40, n);
      // cycles from start/handshake cycle to valid, inclusive
      check("period", 384'(n + 1), 384'(NCH + 1));
      check_next_vec(i);
      tick();
    end
    check("run_done", 384'(done), 384'(1));
    check("run_busy", 384'(busy), 384'(0));
    check("run_valid", 384'(vec_valid), 384'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;

    tick();
    tick();
    check("rst_valid", 384'(vec_valid), 384'(0));
    check("rst_data",  384'(vec_data),  384'(0));
    check("rst_index", 384'(vec_index), 384'(0));
    check("rst_busy",  384'(busy),      384'(0));
    check("rst_done",  384'(done),      384'(0));
    rst = 1'b0;
    tick();

    // Seed 1, one 32-bit chunk, one vector.
    seed_load1 = 1'b1; seed_in1 = 32'd1; start1 = 1'b1;
    tick();
    seed_load1 = 1'b0; start1 = 1'b0;
    n = 0;
    while (!vec_valid1 && n < 10) begin
      tick();
      n++;
    end
    check("u1_latency", 384'(n + 1), 384'(2));
    check("u1_data",  384'(vec_data1),  384'(32'h41C67EA6));
    check("u1_index", 384'(vec_index1), 384'(0));
    vec_ready1 = 1'b1;
    tick();
    vec_ready1 = 1'b0;
    check("u1_done",  384'(done1),      384'(1));
    check("u1_busy",  384'(busy1),      384'(0));
    check("u1_valid", 384'(vec_valid1), 384'(0));

    // Seed 0 on the full-width instance.
    m_state = 32'd0;
    seed_load = 1'b1; seed_in = 32'd0; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    gen_expected();
    check("start_busy",  384'(busy),      384'(1));
    check("start_valid", 384'(vec_valid), 384'(0));
    wait_valid(40, n);
    check("first_latency", 384'(n + 1), 384'(12));
    check("chunk0", 384'(vec_data[31:0]),  384'(32'h00003039));
    check("chunk1", 384'(vec_data[63:32]), 384'(32'hD3DC167E));
    check_next_vec(0);

    // Backpressure: 50 cycles without vec_ready.
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_valid", 384'(vec_valid), 384'(1));
      check("bp_data",  384'(vec_data),  384'(last_exp));
      check("bp_index", 384'(vec_index), 384'(0));
    end
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    gen_expected();
    check("hs_valid", 384'(vec_valid), 384'(0));
    check("hs_busy",  384'(busy),      384'(1));
    wait_valid(40, n);
    check("bp_release_latency", 384'(n + 1), 384'(12));
    check_next_vec(1);

    // start while presenting is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_pres_valid", 384'(vec_valid), 384'(1));
    check("start_pres_data",  384'(vec_data),  384'(last_exp));
    check("start_pres_index", 384'(vec_index), 384'(1));

    // seed_load during generation is ignored.
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    gen_expected();
    tick();
    tick();
    seed_load = 1'b1; seed_in = 32'hDEADBEEF;
    tick();
    seed_load = 1'b0;
    wait_valid(40, n);
    check_next_vec(2);

    // Reset in cycle 5 of a run.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_busy_before", 384'(busy), 384'(1));
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 384'(vec_valid), 384'(0));
    check("mid_rst_data",  384'(vec_data),  384'(0));
    check("mid_rst_index", 384'(vec_index), 384'(0));
    check("mid_rst_busy",  384'(busy),      384'(0));
    check("mid_rst_done",  384'(done),      384'(0));
    rst = 1'b0;
    tick();
    check("post_rst_valid", 384'(vec_valid), 384'(0));

    // Full run from the default seed, then a continuation run.
    m_state = DSEED;
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    run_vectors();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_vectors();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
